fetch_pc_ir: RTL
================

Name: fetch_pc_ir

Overview:
- Multicycle-MIPS fetch/holding stage: PC register, instruction register (IR), memory data register (MDR) and next-PC selection.
- Sits directly upstream of the control unit: supplies Opcode/Funct decoded from IR.
- Consumes the control unit's PCWrite, Branch, PCSrc, IorD and IRWrite to drive the unified memory address and update PC/IR.
- Also keeps a retired-instruction counter and a sticky misalignment flag for debug.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- CNT_W, 32, width of the instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- PCWrite  in  1  unconditional PC update enable, from control unit.
- Branch  in  1  conditional PC update enable (beq), from control unit.
- PCSrc  in  2  next-PC select, from control unit.
- IorD  in  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  in  1  IR load enable, from control unit.
- Zero  in  1  ALU zero flag, combinational from ALU.
- ALUResult  in  32  combinational ALU output.
- ALUOut  in  32  registered ALU output.
- RD  in  32  memory read data.
- Adr  out  32  memory address.
- PC  out  32  current program counter.
- Instr  out  32  IR contents.
- Opcode  out  6  Instr[31:26].
- Funct  out  6  Instr[5:0].
- Rs, Rt, Rd  out  5 each  Instr[25:21], [20:16], [15:11].
- SignImm  out  32  sign-extended Instr[15:0].
- ZeroImm  out  32  zero-extended Instr[15:0].
- Data  out  32  MDR contents.
- instr_count  out  CNT_W  number of IR loads since reset.
- pc_misalign  out  1  sticky flag: PC was ever loaded with PC[1:0] != 0.

Behaviour:
- Reset (async, rst_n = 0):
  - PC = RESET_PC; Instr = 0; Data = 0; instr_count = 0; pc_misalign = 0.
  - Therefore Opcode = Funct = 0, and all IR-derived fields are 0.
  - Reset mid-operation discards any pending update. The first edge after deassertion behaves normally.
- Register updates occur on the rising edge only. All outputs not listed below are registered or pure slices of registers.
- PCEn = PCWrite | (Branch & Zero). When PCEn = 1, PC <= PCNext; otherwise PC holds.
- PCNext:
  - 00 = ALUResult.
  - 01 = ALUOut.
  - 10 = jump target {PC[31:28], Instr[25:0], 2'b00}, using the current (pre-update) PC and IR.
  - 11 = reserved; PCNext = PC, so PC holds even if PCEn = 1.
- Branch = 1 with Zero = 0 and PCWrite = 0: PC holds (branch not taken).
- IR: loads RD when IRWrite = 1, else holds.
- MDR: Data <= RD every cycle, unconditionally.
- Adr = IorD ? ALUOut : PC. Combinational, zero latency.
- Simultaneous IRWrite and PCEn (fetch cycle): on the same edge, IR captures RD read at the old PC and PC takes PCNext. No hazard: both sample pre-edge values.
- instr_count increments by 1 on each edge with IRWrite = 1. Wraps from all-ones to 0 silently.
- pc_misalign is set on any edge where PCEn = 1 and PCNext[1:0] != 0. It is set even for the reserved-hold case. Cleared only by reset. PC is still loaded with the misaligned value; no correction.
- Immediates: SignImm = {{16{Instr[15]}}, Instr[15:0]}; ZeroImm = {16'b0, Instr[15:0]}.
- No internal FSM. Sequencing is owned by the control unit; this block is strictly enable-driven.

Decomposition:
- Shared package: PCSrc encodings PCSRC_ALURES = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10, PCSRC_RSVD = 2'b11; RESET_PC default; IR field bit positions.
- One natural sub-module, en_reg: parameterised-width, async active-low reset, enable-gated flip-flop register. Instantiated for PC, IR and MDR (MDR with enable tied high).

Test Plan:
- Reset: assert rst_n = 0 mid-cycle with PCWrite = 1 -> immediately PC = 32'h0040_0000, Instr = 0, instr_count = 0, pc_misalign = 0, Adr = 32'h0040_0000.
- Fetch: RD = 32'h2008_0005, IRWrite = 1, PCWrite = 1, PCSrc = 00, ALUResult = 32'h0040_0004 -> after one edge: Instr = 32'h2008_0005, Opcode = 6'h08, Rt = 8, SignImm = 5, PC = 32'h0040_0004, instr_count = 1.
- Branch: Branch = 1, PCSrc = 01, ALUOut = 32'h0040_0020.
  - Zero = 0 -> PC unchanged.
  - Zero = 1 -> PC = 32'h0040_0020.
- Jump: PC = 32'h0040_0008, Instr = 32'h0810_0010, PCSrc = 10, PCWrite = 1 -> PC = 32'h0040_0040.
- Memory access: IorD = 1, ALUOut = 32'h1001_0000 -> Adr = 32'h1001_0000 same cycle. RD = 32'hDEAD_BEEF -> Data = 32'hDEAD_BEEF next edge; Instr unchanged with IRWrite = 0.
- Boundaries:
  - PCWrite = 1, ALUResult = 32'h0040_0002 -> PC = 32'h0040_0002 and pc_misalign = 1, held until reset.
  - PCSrc = 11 with PCWrite = 1 -> PC holds.
  - Force instr_count = all-ones, then IRWrite -> instr_count = 0.

Source files
------------

// File: rtl/fetch_pc_ir_pkg.sv
// Shared definitions for the multicycle fetch/holding stage:
// next-PC select encodings, reset PC default, instruction field layout
// and the jump-target helper used by the PC mux.
package fetch_pc_ir_pkg;

  // Next-PC select encodings driven by the control unit.
  localparam logic [1:0] PCSRC_ALURES = 2'b00;  // ALU result (PC+4 during fetch)
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;  // registered ALU output (branch target)
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;  // pseudo-direct jump target
  localparam logic [1:0] PCSRC_RSVD   = 2'b11;  // reserved: PC reloads itself

  // Default reset PC: start of the MIPS text segment.
  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;

  // Instruction register field bit positions.
  localparam int IR_OP_HI  = 31;
  localparam int IR_OP_LO  = 26;
  localparam int IR_RS_HI  = 25;
  localparam int IR_RS_LO  = 21;
  localparam int IR_RT_HI  = 20;
  localparam int IR_RT_LO  = 16;
  localparam int IR_RD_HI  = 15;
  localparam int IR_RD_LO  = 11;
  localparam int IR_FN_HI  = 5;
  localparam int IR_FN_LO  = 0;
  localparam int IR_IMM_HI = 15;
  localparam int IR_IMM_LO = 0;
  localparam int IR_JT_HI  = 25;
  localparam int IR_JT_LO  = 0;

  // R-type view of an instruction word; the field order matches the
  // bit positions above so a plain cast yields the decoded fields.
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_fields_t;

  // Pseudo-direct jump target: upper nibble of the current PC, 26-bit
  // word index from the instruction, word aligned.
  function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                              input logic [31:0] ir);
    return {pc[31:28], ir[IR_JT_HI:IR_JT_LO], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_ir_if.sv
// Bus between the fetch/holding stage and its neighbours (control unit,
// ALU, unified memory). The master side drives enables and data in;
// the slave side is the fetch stage itself.
interface fetch_pc_ir_if #(
  parameter int CNT_W = 32
);

  // Control unit enables and selects.
  logic              PCWrite;
  logic              Branch;
  logic [1:0]        PCSrc;
  logic              IorD;
  logic              IRWrite;

  // Datapath and memory inputs.
  logic              Zero;
  logic [31:0]       ALUResult;
  logic [31:0]       ALUOut;
  logic [31:0]       RD;

  // Stage outputs.
  logic [31:0]       Adr;
  logic [31:0]       PC;
  logic [31:0]       Instr;
  logic [5:0]        Opcode;
  logic [5:0]        Funct;
  logic [4:0]        Rs;
  logic [4:0]        Rt;
  logic [4:0]        Rd;
  logic [31:0]       SignImm;
  logic [31:0]       ZeroImm;
  logic [31:0]       Data;
  logic [CNT_W-1:0]  instr_count;
  logic              pc_misalign;

  modport master (
    output PCWrite, Branch, PCSrc, IorD, IRWrite,
    output Zero, ALUResult, ALUOut, RD,
    input  Adr, PC, Instr, Opcode, Funct, Rs, Rt, Rd,
    input  SignImm, ZeroImm, Data, instr_count, pc_misalign
  );

  modport slave (
    input  PCWrite, Branch, PCSrc, IorD, IRWrite,
    input  Zero, ALUResult, ALUOut, RD,
    output Adr, PC, Instr, Opcode, Funct, Rs, Rt, Rd,
    output SignImm, ZeroImm, Data, instr_count, pc_misalign
  );

endinterface

// File: rtl/fetch_pc_ir_en_reg.sv
// Purpose: W-bit enable-gated register with async active-low reset to RST_VAL.
// Latency: one clock edge from d_i to q_o when en_i is high.
// Backpressure: none; en_i low simply holds the stored value.
module fetch_pc_ir_en_reg #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  // Capture d_i on enabled edges, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RST_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_pc_ir.sv
// Purpose: multicycle-MIPS PC/IR/MDR holding stage with next-PC select and IR field decode.
// Latency: registers update on the edge their enable is seen; Adr and IR-field outputs are combinational.
// Backpressure: none; the control unit sequences everything through PCWrite/Branch/IRWrite.
module fetch_pc_ir
  import fetch_pc_ir_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  // Must match the CNT_W of the connected fetch_pc_ir_if instance.
  parameter int          CNT_W    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_pc_ir_if.slave  bus
);

  logic              pc_en;
  logic [31:0]       pc_next_d;
  logic [31:0]       pc_q;
  logic [31:0]       ir_q;
  logic [31:0]       mdr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              mis_q;
  logic              mis_d;
  instr_fields_t     ir_f;

  // A taken beq (Branch with Zero) writes PC just like an unconditional update.
  assign pc_en = bus.PCWrite | (bus.Branch & bus.Zero);

  // Next-PC mux; the jump target is built from the pre-edge PC and IR.
  // The reserved code reloads the current PC so an enabled write is a no-op.
  always_comb begin
    pc_next_d = pc_q;
    case (bus.PCSrc)
      PCSRC_ALURES: pc_next_d = bus.ALUResult;
      PCSRC_ALUOUT: pc_next_d = bus.ALUOut;
      PCSRC_JUMP:   pc_next_d = jump_target(pc_q, ir_q);
      PCSRC_RSVD:   pc_next_d = pc_q;
      default:      pc_next_d = pc_q;
    endcase
  end

  // Program counter.
  fetch_pc_ir_en_reg #(
    .W       (32),
    .RST_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (pc_en),
    .d_i   (pc_next_d),
    .q_o   (pc_q)
  );

  // Instruction register; in a fetch cycle it captures RD read at the old
  // PC on the same edge that PC advances, since both sample pre-edge values.
  fetch_pc_ir_en_reg #(
    .W       (32),
    .RST_VAL (32'h0)
  ) u_ir_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (bus.IRWrite),
    .d_i   (bus.RD),
    .q_o   (ir_q)
  );

  // Memory data register: samples the read bus every cycle.
  fetch_pc_ir_en_reg #(
    .W       (32),
    .RST_VAL (32'h0)
  ) u_mdr_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (1'b1),
    .d_i   (bus.RD),
    .q_o   (mdr_q)
  );

  // Retired-instruction count (one per IR load, wraps silently) and the
  // sticky misalignment flag, which also fires on a reserved-select hold.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.IRWrite) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    mis_d = mis_q | (pc_en & (|pc_next_d[1:0]));
  end

  // Debug state registers; only reset clears the misalignment flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      mis_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mis_q <= mis_d;
    end
  end

  // Field decode straight off the IR.
  assign ir_f = instr_fields_t'(ir_q);

  // Unified memory address: PC for fetch, ALUOut for loads/stores.
  assign bus.Adr         = bus.IorD ? bus.ALUOut : pc_q;
  assign bus.PC          = pc_q;
  assign bus.Instr       = ir_q;
  assign bus.Opcode      = ir_f.opcode;
  assign bus.Funct       = ir_f.funct;
  assign bus.Rs          = ir_f.rs;
  assign bus.Rt          = ir_f.rt;
  assign bus.Rd          = ir_f.rd;
  assign bus.SignImm     = {{16{ir_q[IR_IMM_HI]}}, ir_q[IR_IMM_HI:IR_IMM_LO]};
  assign bus.ZeroImm     = {16'h0000, ir_q[IR_IMM_HI:IR_IMM_LO]};
  assign bus.Data        = mdr_q;
  assign bus.instr_count = cnt_q;
  assign bus.pc_misalign = mis_q;

endmodule
